uart_rx_engine: RTL and testbench

Serial receive engine for the UART; the receive-side counterpart of the transmit bit decoder. It samples the asynchronous rx line, validates the start bit at mid-bit, and shifts in 7 or 8 data bits, an optional parity bit and one stop bit. It then presents the data byte with parity, framing and overrun status to the host-side register interface. Frame format is selected by the same bit_8 / parity_en / odd_n_even controls the transmitter uses.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_rx_engine_if.sv | 25 ++
 rtl/uart_baud_timer.sv | 23 ++
 rtl/uart_rx_engine.sv | 119 +++++++++++
 tb/tb_uart_rx_engine.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding, frame sizing and helpers
// used by both the receive engine and the transmitter.
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, DONE} rx_state_e;

   localparam int MAX_FRAME = 10;

   // Bits following the start bit: data (7/8) + optional parity + stop.
   function automatic logic [3:0] frame_len(input logic bit_8, input logic parity_en);
      return 4'd8 + {3'b000, bit_8} + {3'b000, parity_en};
   endfunction
endpackage

// File: rtl/uart_rx_engine_if.sv
// Host/line-side bundle of the UART receive engine: serial line, frame
// format controls, bit timing and the received-byte status.
interface uart_rx_engine_if #(parameter int BAUD_W = 19);
   logic              rx;
   logic [BAUD_W-1:0] baud_k;
   logic              bit_8;
   logic              parity_en;
   logic              odd_n_even;
   logic              clr_rdy;
   logic [7:0]        rx_data;
   logic              rx_rdy;
   logic              perr;
   logic              ferr;
   logic              ovf;

   modport master (
      output rx, baud_k, bit_8, parity_en, odd_n_even, clr_rdy,
      input  rx_data, rx_rdy, perr, ferr, ovf
   );

   modport slave (
      input  rx, baud_k, bit_8, parity_en, odd_n_even, clr_rdy,
      output rx_data, rx_rdy, perr, ferr, ovf
   );
endinterface

// File: rtl/uart_baud_timer.sv
// Bit-time counter with synchronous clear and half/full terminal-count flags;
// shared by the UART receive and transmit paths.
module uart_baud_timer #(
   parameter int W = 19
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic [W-1:0] baud_k,
   output logic         half_tc,
   output logic         full_tc
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)    cnt <= '0;
      else if (clr) cnt <= '0;
      else          cnt <= cnt + 1'b1;
   end

   assign half_tc = (cnt == (baud_k >> 1));
   assign full_tc = (cnt == baud_k - 1'b1);
endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, qualifies the start bit at mid-bit,
// shifts in data/parity/stop and presents the byte with error status.
module uart_rx_engine #(
   parameter int BAUD_W = 19
) (
   input  logic             clk,
   input  logic             reset,
   uart_rx_engine_if.slave  bus
);
   import uart_pkg::*;

   rx_state_e              state;
   logic                   rx_s1, rxs, rxs_q;
   logic [3:0]             bitcnt, nlen;
   logic [MAX_FRAME-1:0]   sreg;
   logic                   b8_q, pen_q, odd_q;
   logic                   half_tc, full_tc, tmr_clr;
   logic [7:0]             data_r;
   logic                   rdy_r, perr_r, ferr_r, ovf_r;

   logic [3:0]             shamt;
   logic [MAX_FRAME-1:0]   aligned;
   logic [7:0]             data_w;
   logic                   par_w, stop_w;

   // Timer restarts at every terminal count so a bit never wraps the counter.
   assign tmr_clr = (state == IDLE) || (state == DONE) ||
                    ((state == START) && half_tc) ||
                    ((state == DATA) && full_tc);

   uart_baud_timer #(.W(BAUD_W)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (tmr_clr),
      .baud_k  (bus.baud_k),
      .half_tc (half_tc),
      .full_tc (full_tc)
   );

   // The first received bit sits at sreg[MAX_FRAME-nlen] once all nlen are in.
   always_comb begin
      shamt   = 4'(MAX_FRAME) - nlen;
      aligned = sreg >> shamt;
      data_w  = b8_q ? aligned[7:0] : {1'b0, aligned[6:0]};
      par_w   = b8_q ? aligned[8] : aligned[7];
      stop_w  = aligned[nlen - 4'd1];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         rx_s1  <= 1'b1;
         rxs    <= 1'b1;
         rxs_q  <= 1'b1;
         bitcnt <= '0;
         nlen   <= '0;
         sreg   <= '0;
         b8_q   <= 1'b0;
         pen_q  <= 1'b0;
         odd_q  <= 1'b0;
         data_r <= '0;
         rdy_r  <= 1'b0;
         perr_r <= 1'b0;
         ferr_r <= 1'b0;
         ovf_r  <= 1'b0;
      end else begin
         rx_s1 <= bus.rx;
         rxs   <= rx_s1;
         rxs_q <= rxs;

         if (bus.clr_rdy) begin
            rdy_r  <= 1'b0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            ovf_r  <= 1'b0;
         end

         case (state)
            IDLE: begin
               // Falling edge only: a line stuck low after a framing error is ignored.
               if (!rxs && rxs_q) begin
                  state  <= START;
                  bitcnt <= '0;
                  b8_q   <= bus.bit_8;
                  pen_q  <= bus.parity_en;
                  odd_q  <= bus.odd_n_even;
                  nlen   <= frame_len(bus.bit_8, bus.parity_en);
               end
            end
            START: begin
               if (half_tc) state <= rxs ? IDLE : DATA;
            end
            DATA: begin
               if (full_tc) begin
                  sreg   <= {rxs, sreg[MAX_FRAME-1:1]};
                  bitcnt <= bitcnt + 4'd1;
                  if (bitcnt + 4'd1 == nlen) state <= DONE;
               end
            end
            DONE: begin
               // Completion takes priority over a coincident clr_rdy.
               data_r <= data_w;
               perr_r <= pen_q & ((^data_w ^ par_w) != odd_q);
               ferr_r <= ~stop_w;
               rdy_r  <= 1'b1;
               ovf_r  <= ~bus.clr_rdy & (ovf_r | rdy_r);
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rx_data = data_r;
   assign bus.rx_rdy  = rdy_r;
   assign bus.perr    = perr_r;
   assign bus.ferr    = ferr_r;
   assign bus.ovf     = ovf_r;
endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: directed frame table, multi-cycle
// corner sequences and random frames against a frame-level reference model.
module tb_uart_rx_engine;
   logic clk = 1'b0;
   logic reset = 1'b1;

   uart_rx_engine_if #(.BAUD_W(19)) bus();

   uart_rx_engine #(.BAUD_W(19)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   rise_cyc = 0;
   int   start_cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   k = 16;
   logic rdy_q = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rx_rdy && !rdy_q) rise_cyc <= cyc;
      rdy_q <= bus.rx_rdy;
   end

   typedef struct {
      logic [7:0] d;
      bit         b8, pen, odd, pbit, stopb;
      logic [7:0] ed;
      bit         ep, ef;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.clr_rdy = 1'b1;
      tick(1);
      bus.clr_rdy = 1'b0;
   endtask

   // Drives one frame, leaving rx at the stop-bit level afterwards.
   task automatic send(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                       input bit pbit, input bit stopb);
      @(posedge clk);
      #1;
      bus.baud_k     = 19'(k);
      bus.bit_8      = b8;
      bus.parity_en  = pen;
      bus.odd_n_even = odd;
      tick(1);
      bus.rx    = 1'b0;
      start_cyc = cyc;
      tick(k);
      for (int i = 0; i < 7 + int'(b8); i++) begin
         bus.rx = d[i];
         tick(k);
      end
      if (pen) begin
         bus.rx = pbit;
         tick(k);
      end
      bus.rx = stopb;
      tick(k);
   endtask

   // Frame-level expectations: what a correct receiver reports for the bits on the line.
   task automatic model(input logic [7:0] d, input bit b8, input bit pen, input bit odd,
                        input bit pbit, input bit stopb,
                        output logic [7:0] ed, output bit ep, output bit ef);
      int ones;
      bit want;
      ed   = b8 ? d : (d & 8'h7F);
      ones = $countones(ed);
      want = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
      ep   = pen && (pbit != want);
      ef   = !stopb;
   endtask

   // rx_rdy rises 2 sync clks + 1 detect + half bit + 1 decision + n bit times + 1 after the start edge.
   function automatic int exp_lat(input bit b8, input bit pen);
      return 5 + (k / 2) + k * (8 + int'(b8) + int'(pen));
   endfunction

   task automatic check_frame(input string tag, input logic [7:0] ed, input bit ep, input bit ef,
                              input bit b8, input bit pen);
      check({tag, " data"}, bus.rx_data, ed);
      check({tag, " perr"}, bus.perr, ep);
      check({tag, " ferr"}, bus.ferr, ef);
      check({tag, " rdy"}, bus.rx_rdy, 1);
      check({tag, " ovf"}, bus.ovf, 0);
      check({tag, " latency"}, rise_cyc - start_cyc, exp_lat(b8, pen));
   endtask

   initial begin
      logic [7:0] ed, d;
      bit ep, ef, b8, pen, odd, pbit, stopb;

      tbl[0] = '{8'h0F, 1, 0, 0, 0, 1, 8'h0F, 0, 0};
      tbl[1] = '{8'hA5, 1, 1, 0, 0, 1, 8'hA5, 0, 0};
      tbl[2] = '{8'hA5, 1, 1, 0, 1, 1, 8'hA5, 1, 0};
      tbl[3] = '{8'h41, 0, 1, 1, 1, 1, 8'h41, 0, 0};
      tbl[4] = '{8'hC1, 0, 1, 1, 1, 1, 8'h41, 0, 0};
      tbl[5] = '{8'h55, 1, 0, 0, 0, 0, 8'h55, 0, 1};
      tbl[6] = '{8'h00, 1, 1, 1, 1, 1, 8'h00, 0, 0};
      tbl[7] = '{8'h7F, 0, 1, 0, 0, 1, 8'h7F, 1, 0};

      bus.rx = 1'b1;
      bus.baud_k = 19'd16;
      bus.bit_8 = 1'b1;
      bus.parity_en = 1'b0;
      bus.odd_n_even = 1'b0;
      bus.clr_rdy = 1'b0;
      tick(3);
      check("reset data", bus.rx_data, 0);
      check("reset rdy", bus.rx_rdy, 0);
      check("reset flags", {bus.perr, bus.ferr, bus.ovf}, 0);
      reset = 1'b0;
      tick(3);

      k = 16;
      foreach (tbl[i]) begin
         send(tbl[i].d, tbl[i].b8, tbl[i].pen, tbl[i].odd, tbl[i].pbit, tbl[i].stopb);
         bus.rx = 1'b1;
         tick(2);
         check_frame($sformatf("vec%0d", i), tbl[i].ed, tbl[i].ep, tbl[i].ef, tbl[i].b8, tbl[i].pen);
         clr();
         check($sformatf("vec%0d cleared", i), {bus.rx_rdy, bus.perr, bus.ferr, bus.ovf}, 0);
         tick(k);
      end

      // Short low glitch must not start a frame.
      bus.rx = 1'b0;
      tick(4);
      bus.rx = 1'b1;
      tick(4 * k);
      check("glitch rdy", bus.rx_rdy, 0);
      send(8'h5A, 1, 0, 0, 0, 1);
      tick(2);
      check("after glitch data", bus.rx_data, 8'h5A);
      check("after glitch rdy", bus.rx_rdy, 1);
      clr();
      tick(k);

      // Framing error, then the line stays low: no new frame until it goes high again.
      send(8'h55, 1, 0, 0, 0, 0);
      tick(2);
      check("ferr flag", bus.ferr, 1);
      check("ferr rdy", bus.rx_rdy, 1);
      clr();
      tick(20 * k);
      check("held low rdy", bus.rx_rdy, 0);
      bus.rx = 1'b1;
      tick(k);
      send(8'h3C, 1, 0, 0, 0, 1);
      bus.rx = 1'b1;
      tick(2);
      check("post ferr data", bus.rx_data, 8'h3C);
      check("post ferr ferr", bus.ferr, 0);
      clr();
      tick(k);

      // Back-to-back frames without a clear.
      send(8'h12, 1, 0, 0, 0, 1);
      send(8'h34, 1, 0, 0, 0, 1);
      tick(2);
      check("overrun data", bus.rx_data, 8'h34);
      check("overrun ovf", bus.ovf, 1);
      check("overrun rdy", bus.rx_rdy, 1);
      clr();
      check("overrun cleared", {bus.rx_rdy, bus.perr, bus.ferr, bus.ovf}, 0);
      tick(k);

      // Reset in the middle of the data bits.
      send(8'h77, 1, 0, 0, 0, 1);
      tick(k);
      bus.rx = 1'b0;
      tick(k);
      bus.rx = 1'b1;
      tick(k);
      bus.rx = 1'b0;
      tick(k / 2);
      reset = 1'b1;
      tick(1);
      check("midreset rdy", bus.rx_rdy, 0);
      check("midreset data", bus.rx_data, 0);
      check("midreset ovf", bus.ovf, 0);
      reset = 1'b0;
      bus.rx = 1'b1;
      tick(3 * k);
      send(8'hE7, 1, 0, 0, 0, 1);
      tick(2);
      check_frame("post reset", 8'hE7, 0, 0, 1, 0);
      clr();
      tick(k);

      // Random formats, data, parity and stop bits against the model.
      for (int r = 0; r < 40; r++) begin
         k     = $urandom_range(10, 40);
         d     = 8'($urandom);
         b8    = 1'($urandom);
         pen   = 1'($urandom);
         odd   = 1'($urandom);
         pbit  = 1'($urandom);
         stopb = ($urandom_range(0, 7) != 0);
         model(d, b8, pen, odd, pbit, stopb, ed, ep, ef);
         send(d, b8, pen, odd, pbit, stopb);
         bus.rx = 1'b1;
         tick(2);
         check_frame($sformatf("rnd%0d", r), ed, ep, ef, b8, pen);
         clr();
         check($sformatf("rnd%0d cleared", r), bus.rx_rdy, 0);
         tick(k);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
